// File: rtl/top_sweep_ctrl_pkg.sv
// Shared definitions for the Top sweep sequencer: state encoding, sweep length,
// and the per-vector compare helper.
package top_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SWEEP_LEN = 8;
    localparam logic [2:0] LAST_IDX = 3'(SWEEP_LEN - 1);

    function automatic logic vec_mismatch(
        input logic       f1,
        input logic       f2,
        input logic [7:0] exp_f1,
        input logic [7:0] exp_f2,
        input logic [2:0] idx
    );
        return (f1 != exp_f1[idx]) | (f2 != exp_f2[idx]);
    endfunction

endpackage

// File: rtl/top_sweep_ctrl_if.sv
// Control/status and Top-facing signals of the sweep sequencer.
// master = sequencer side, slave = the wrapper driving start/abort and returning F1/F2.
interface top_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       A;
    logic       C;
    logic       D;
    logic       F1;
    logic       F2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;

    modport master (
        input  start, abort, F1, F2,
        output A, C, D, busy, done, pass, err_count, first_err_idx
    );

    modport slave (
        output start, abort, F1, F2,
        input  A, C, D, busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/top_sweep_ctrl_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the final cycle.
module sweep_dwell_timer #(
    parameter int unsigned DWELL = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam logic [15:0] LAST_CNT = 16'(DWELL - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= last ? 16'd0 : r_cnt + 16'd1;
        end
    end

    assign last = (r_cnt == LAST_CNT);
endmodule

// File: rtl/top_sweep_ctrl.sv
// Sweeps Top through all 8 {D,C,A} vectors, holding each for DWELL cycles and
// checking F1/F2 against the expected truth tables on the last dwell cycle.
module top_sweep_ctrl
    import top_sweep_ctrl_pkg::*;
#(
    parameter int unsigned DWELL  = 100,
    parameter logic [7:0]  EXP_F1 = 8'h00,
    parameter logic [7:0]  EXP_F2 = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    top_sweep_ctrl_if.master bus
);
    state_t     r_state, w_state_next;
    logic [2:0] r_idx, w_idx_next;
    logic [3:0] r_err_count, w_err_count_next;
    logic [2:0] r_first_err_idx, w_first_err_idx_next;
    logic       r_busy, w_busy_next;
    logic       r_done, w_done_next;
    logic       w_tmr_clr, w_tmr_en, w_last, w_mismatch;

    assign w_mismatch = vec_mismatch(bus.F1, bus.F2, EXP_F1, EXP_F2, r_idx);

    sweep_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tmr_clr),
        .en   (w_tmr_en),
        .last (w_last)
    );

    always_comb begin
        w_state_next         = r_state;
        w_idx_next           = r_idx;
        w_err_count_next     = r_err_count;
        w_first_err_idx_next = r_first_err_idx;
        w_busy_next          = r_busy;
        w_done_next          = r_done;
        w_tmr_clr            = 1'b0;
        w_tmr_en             = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_next         = ST_APPLY;
                    w_idx_next           = 3'd0;
                    w_err_count_next     = 4'd0;
                    w_first_err_idx_next = 3'd0;
                    w_busy_next          = 1'b1;
                    w_done_next          = 1'b0;
                    w_tmr_clr            = 1'b1;
                end
            end
            ST_APPLY: begin
                // abort discards any compare landing in the same cycle
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = 3'd0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b0;
                    w_tmr_clr    = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                    if (w_last) begin
                        if (w_mismatch) begin
                            w_err_count_next = r_err_count + 4'd1;
                            if (r_err_count == 4'd0) begin
                                w_first_err_idx_next = r_idx;
                            end
                        end
                        if (r_idx == LAST_IDX) begin
                            w_state_next = ST_DONE;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_idx_next = r_idx + 3'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = 3'd0;
                w_busy_next  = 1'b0;
                w_done_next  = 1'b0;
                w_tmr_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_idx           <= 3'd0;
            r_err_count     <= 4'd0;
            r_first_err_idx <= 3'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_idx           <= w_idx_next;
            r_err_count     <= w_err_count_next;
            r_first_err_idx <= w_first_err_idx_next;
            r_busy          <= w_busy_next;
            r_done          <= w_done_next;
        end
    end

    assign bus.A             = r_idx[0];
    assign bus.C             = r_idx[1];
    assign bus.D             = r_idx[2];
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.pass          = r_done & (r_err_count == 4'd0);
    assign bus.err_count     = r_err_count;
    assign bus.first_err_idx = r_first_err_idx;
endmodule
